// File: rtl/spi_register_interface_if.sv
// Bundles the SPI pins and the register-write strobe bus of spi_register_interface.
// slave is the decoder's view; master is the side that drives SCLK/CS_N/MOSI and consumes the writes.
interface spi_register_interface_if;
   logic        i_SPI_SCLK;
   logic        i_SPI_CS_N;
   logic        i_SPI_MOSI;
   logic        o_RegisterWriteEnable;
   logic [15:0] o_RegisterWriteNumber;
   logic [15:0] o_RegisterWriteValue;
   logic        o_FrameError;

   modport slave (
      input  i_SPI_SCLK,
      input  i_SPI_CS_N,
      input  i_SPI_MOSI,
      output o_RegisterWriteEnable,
      output o_RegisterWriteNumber,
      output o_RegisterWriteValue,
      output o_FrameError
   );

   modport master (
      output i_SPI_SCLK,
      output i_SPI_CS_N,
      output i_SPI_MOSI,
      input  o_RegisterWriteEnable,
      input  o_RegisterWriteNumber,
      input  o_RegisterWriteValue,
      input  o_FrameError
   );
endinterface

// File: rtl/spi_register_interface.sv
// SPI mode-0 slave that turns 32-bit frames ({number[15:0], value[15:0]}, MSB first)
// into single-cycle register-write strobes, flagging short or overlong frames.
module spi_register_interface #(
   parameter int SYNC_STAGES = 2
) (
   input  logic                        i_Clock,
   input  logic                        i_Reset,
   spi_register_interface_if.slave     bus
);

   localparam logic [1:0] ST_IDLE         = 2'd0;
   localparam logic [1:0] ST_SHIFT        = 2'd1;
   localparam logic [1:0] ST_WAIT_CS_HIGH = 2'd2;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_n_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic [SYNC_STAGES-1:0] sync_fill;
   logic                   sclk_dly;
   logic                   cs_n_dly;
   logic                   cs_armed;

   logic                   sclk_s;
   logic                   cs_n_s;
   logic                   mosi_s;
   logic                   sclk_rise;
   logic                   cs_fall;
   logic                   cs_rise;

   logic [1:0]             state;
   logic [5:0]             bit_count;
   logic [31:0]            shift_reg;
   logic                   overrun;
   logic                   write_enable;
   logic [15:0]            write_number;
   logic [15:0]            write_value;
   logic                   frame_error;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign cs_n_s = cs_n_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         sclk_sync <= '0;
         cs_n_sync <= '1;
         mosi_sync <= '0;
         sclk_dly  <= 1'b0;
         cs_n_dly  <= 1'b1;
         sync_fill <= '0;
         cs_armed  <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.i_SPI_SCLK};
         cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], bus.i_SPI_CS_N};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.i_SPI_MOSI};
         sclk_dly  <= sclk_s;
         cs_n_dly  <= cs_n_s;
         sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
         // Only a CS_N seen high once the chain has flushed its reset value may start a frame.
         if (sync_fill[SYNC_STAGES-1] && cs_n_s) begin
            cs_armed <= 1'b1;
         end
      end
   end

   assign sclk_rise = sclk_s & ~sclk_dly;
   assign cs_fall   = cs_armed & cs_n_dly & ~cs_n_s;
   assign cs_rise   = ~cs_n_dly & cs_n_s;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state        <= ST_IDLE;
         bit_count    <= '0;
         shift_reg    <= '0;
         overrun      <= 1'b0;
         write_enable <= 1'b0;
         write_number <= '0;
         write_value  <= '0;
         frame_error  <= 1'b0;
      end else begin
         write_enable <= 1'b0;
         frame_error  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cs_fall) begin
                  bit_count <= '0;
                  shift_reg <= '0;
                  overrun   <= 1'b0;
                  state     <= ST_SHIFT;
               end
            end

            ST_SHIFT: begin
               if (bit_count == 6'd32) begin
                  write_number <= shift_reg[31:16];
                  write_value  <= shift_reg[15:0];
                  write_enable <= 1'b1;
                  overrun      <= sclk_rise & ~cs_rise;
                  state        <= cs_rise ? ST_IDLE : ST_WAIT_CS_HIGH;
               end else if (cs_rise) begin
                  // CS_N wins over a simultaneous SCLK edge; an empty frame is silently dropped.
                  frame_error <= (bit_count != 6'd0);
                  state       <= ST_IDLE;
               end else if (sclk_rise) begin
                  shift_reg <= {shift_reg[30:0], mosi_s};
                  bit_count <= bit_count + 6'd1;
               end
            end

            ST_WAIT_CS_HIGH: begin
               if (cs_rise) begin
                  frame_error <= overrun;
                  overrun     <= 1'b0;
                  state       <= ST_IDLE;
               end else if (sclk_rise) begin
                  overrun <= 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_RegisterWriteEnable = write_enable;
   assign bus.o_RegisterWriteNumber = write_number;
   assign bus.o_RegisterWriteValue  = write_value;
   assign bus.o_FrameError          = frame_error;

endmodule

// File: tb/tb_spi_register_interface.sv
// Self-checking bench for spi_register_interface: directed and random SPI frames
// compared against a frame-level model (bit count decides write / error outcome).
module tb_spi_register_interface;

   localparam int SYNC     = 2;
   localparam int HALF     = SYNC + 4;
   localparam int CS_GAP   = SYNC + 4;
   localparam int MIN_GAP  = SYNC + 2;

   logic clk;
   logic rst;

   spi_register_interface_if bus ();

   spi_register_interface #(.SYNC_STAGES(SYNC)) dut (
      .i_Clock (clk),
      .i_Reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          compared   = 0;
   int          mismatched = 0;
   int          cyc        = 0;
   int          act_err    = 0;
   int          overlap    = 0;
   int          last_we_cyc = 0;
   logic [31:0] act_q[$];

   logic [31:0] exp_q[$];
   int          exp_err    = 0;
   int          checked    = 0;
   logic [15:0] model_num  = '0;
   logic [15:0] model_val  = '0;
   int          rise_cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe strobes away from the active edge.
   always @(negedge clk) begin
      if (bus.o_RegisterWriteEnable === 1'b1) begin
         act_q.push_back({bus.o_RegisterWriteNumber, bus.o_RegisterWriteValue});
         last_we_cyc <= cyc;
      end
      if (bus.o_FrameError === 1'b1) act_err <= act_err + 1;
      if (bus.o_RegisterWriteEnable === 1'b1 && bus.o_FrameError === 1'b1) overlap <= overlap + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic spi_wait(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Clocks n bits MSB-first from bits[63]; with coincident set, CS_N rises together with the last SCLK rise.
   task automatic clock_bits(input logic [63:0] bits, input int n, input bit coincident);
      for (int i = 0; i < n; i++) begin
         bus.i_SPI_MOSI = bits[63-i];
         spi_wait(HALF);
         if (coincident && i == n - 1) bus.i_SPI_CS_N = 1'b1;
         bus.i_SPI_SCLK = 1'b1;
         if (i == 31) rise_cyc = cyc;
         spi_wait(HALF);
         bus.i_SPI_SCLK = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [63:0] bits, input int n, input bit coincident, input int gap);
      int eff;
      bus.i_SPI_CS_N = 1'b0;
      spi_wait(HALF);
      clock_bits(bits, n, coincident);
      if (!coincident || n == 0) begin
         spi_wait(HALF);
         bus.i_SPI_CS_N = 1'b1;
      end
      spi_wait(gap);
      eff = (coincident && n > 0) ? n - 1 : n;
      if (eff >= 32) begin
         exp_q.push_back(bits[63:32]);
         model_num = bits[63:48];
         model_val = bits[47:32];
      end
      if ((eff > 0 && eff < 32) || eff > 32) exp_err++;
   endtask

   task automatic verify(input string tag);
      spi_wait(14);
      check({tag, " writes"}, 32'(act_q.size()), 32'(exp_q.size()));
      for (int i = checked; i < exp_q.size() && i < act_q.size(); i++)
         check({tag, " word"}, act_q[i], exp_q[i]);
      checked = exp_q.size();
      check({tag, " errors"}, 32'(act_err), 32'(exp_err));
      check({tag, " number"}, 32'(bus.o_RegisterWriteNumber), 32'(model_num));
      check({tag, " value"},  32'(bus.o_RegisterWriteValue),  32'(model_val));
   endtask

   task automatic check_outputs_zero(input string tag);
      @(negedge clk);
      check({tag, " we"},     32'(bus.o_RegisterWriteEnable), 32'd0);
      check({tag, " err"},    32'(bus.o_FrameError),          32'd0);
      check({tag, " number"}, 32'(bus.o_RegisterWriteNumber), 32'd0);
      check({tag, " value"},  32'(bus.o_RegisterWriteValue),  32'd0);
   endtask

   initial begin
      logic [63:0] bits;
      int          lat;
      int          len;

      // CS_N held low through reset must not open a frame.
      rst            = 1'b1;
      bus.i_SPI_CS_N = 1'b0;
      bus.i_SPI_SCLK = 1'b0;
      bus.i_SPI_MOSI = 1'b0;
      spi_wait(5);
      check_outputs_zero("reset");
      spi_wait(1);
      rst = 1'b0;
      spi_wait(HALF);
      clock_bits({$urandom, $urandom}, 32, 1'b0);
      spi_wait(HALF);
      bus.i_SPI_CS_N = 1'b1;
      spi_wait(CS_GAP);
      verify("cs_low_at_reset");

      // Single good frame, plus write latency.
      send_frame({32'hC105_1234, 32'h0}, 32, 1'b0, CS_GAP);
      verify("single");
      lat = last_we_cyc - rise_cyc;
      check("latency in window", 32'(lat >= SYNC + 1 && lat <= SYNC + 3), 32'd1);

      // Short frame: error, outputs hold.
      send_frame({16'h4000, 48'h0}, 16, 1'b0, CS_GAP);
      verify("short16");

      // Overlong frame: write after bit 32, error at CS_N high.
      send_frame({32'hC3FF_00AA, $urandom}, 40, 1'b0, CS_GAP);
      verify("long40");

      // Reset mid-frame discards silently and clears the outputs.
      bus.i_SPI_CS_N = 1'b0;
      spi_wait(HALF);
      clock_bits({$urandom, $urandom}, 20, 1'b0);
      spi_wait(2);
      rst = 1'b1;
      spi_wait(3);
      check_outputs_zero("mid_reset");
      bus.i_SPI_CS_N = 1'b1;
      spi_wait(3);
      rst = 1'b0;
      model_num = '0;
      model_val = '0;
      spi_wait(HALF);
      verify("after_reset");
      send_frame({32'h4001_0007, 32'h0}, 32, 1'b0, CS_GAP);
      verify("post_reset_frame");

      // Back-to-back frames at the minimum CS_N high time.
      send_frame({32'hC000_0100, 32'h0}, 32, 1'b0, MIN_GAP);
      send_frame({32'hC001_0200, 32'h0}, 32, 1'b0, CS_GAP);
      verify("back_to_back");

      // CS_N rise on the 32nd SCLK edge.
      send_frame({32'hA5A5_5A5A, 32'h0}, 32, 1'b1, CS_GAP);
      verify("coincident");

      // Empty frame: neither write nor error.
      send_frame(64'h0, 0, 1'b0, CS_GAP);
      verify("empty");

      // Random frames of random length.
      for (int k = 0; k < 8; k++) begin
         bits = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0:       len = 32;
            1:       len = int'($urandom_range(1, 31));
            2:       len = int'($urandom_range(33, 40));
            default: len = 32;
         endcase
         send_frame(bits, len, 1'b0, CS_GAP);
         verify("random");
      end

      check("strobe_overlap", 32'(overlap), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/spi_register_interface.md
SPI_REGISTER_INTERFACE -- requirements
Module: spi_register_interface

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchroniser flops on each SPI input (legal range 2..4).
REQ-002 SHALL have port i_Clock, input, 1, system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port i_Reset, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port i_SPI_SCLK, input, 1, SPI serial clock, asynchronous to i_Clock, mode 0 (CPOL=0, CPHA=0).
REQ-005 SHALL have port i_SPI_CS_N, input, 1, SPI chip select, active-low, asynchronous.
REQ-006 SHALL have port i_SPI_MOSI, input, 1, SPI serial data, MSB first, asynchronous.
REQ-007 SHALL have port o_RegisterWriteEnable, output, 1, single-cycle strobe feeding synth i_RegisterWriteEnable.
REQ-008 SHALL have port o_RegisterWriteNumber, output, 16, register number feeding synth i_RegisterWriteNumber.
REQ-009 SHALL have port o_RegisterWriteValue, output, 16, register value feeding synth i_RegisterWriteValue.
REQ-010 SHALL have port o_FrameError, output, 1, single-cycle strobe on a malformed frame.

Function
REQ-011 SHALL pass SCLK, CS_N and MOSI each through SYNC_STAGES flops before use; edges SHALL be detected by comparing the last stage with a one-cycle-delayed copy.
REQ-012 SHALL implement states IDLE, SHIFT and WAIT_CS_HIGH.
REQ-013 In IDLE, a synchronised CS_N falling edge SHALL clear the bit counter and the shift register and enter SHIFT; a CS_N that is already low on leaving reset SHALL NOT start a frame.
REQ-014 In SHIFT, each synchronised SCLK rising edge SHALL shift the synchronised MOSI into bit 0 of a 32-bit shift register and increment a 6-bit counter.
REQ-015 The frame format SHALL be bits [31:16] = register number and bits [15:0] = register value, first bit received being bit 31.
REQ-016 When the counter reaches 32, the block SHALL load the number and value output registers, assert o_RegisterWriteEnable for exactly the following i_Clock cycle, and enter WAIT_CS_HIGH.
REQ-017 o_RegisterWriteNumber and o_RegisterWriteValue SHALL hold their values until the next completed frame or reset.
REQ-018 In WAIT_CS_HIGH, further SCLK edges SHALL be ignored but SHALL set an overrun flag; a CS_N rising edge SHALL return the block to IDLE and SHALL pulse o_FrameError for one cycle if the overrun flag is set.
REQ-019 In SHIFT, a CS_N rising edge with counter 1..31 SHALL discard the frame, produce no write strobe, pulse o_FrameError for one cycle and return to IDLE.
REQ-020 In SHIFT, a CS_N rising edge with counter 0 SHALL return to IDLE with neither an error nor a write.
REQ-021 If a CS_N rising edge and an SCLK rising edge are detected in the same cycle, CS_N SHALL take priority and the SCLK edge SHALL be ignored.
REQ-022 Latency from the external 32nd SCLK rising edge to the o_RegisterWriteEnable high cycle SHALL be SYNC_STAGES+2 i_Clock cycles (+/-1 for input phase).
REQ-023 Correct operation SHALL require SCLK high and low times of at least SYNC_STAGES+2 i_Clock periods each, and a CS_N high time of at least the same.
REQ-024 o_RegisterWriteEnable and o_FrameError SHALL never be asserted in the same cycle.

Reset
REQ-025 While i_Reset is high: state SHALL be IDLE, counter 0, shift register 0, and the overrun flag clear.
REQ-026 While i_Reset is high: all outputs SHALL be 0, the CS_N synchronisers SHALL be 1, and the SCLK and MOSI synchronisers SHALL be 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame without a write strobe or an error strobe.

Verification
REQ-028 Single frame 0xC105_1234 -> exactly one o_RegisterWriteEnable pulse, with Number=0xC105 and Value=0x1234; o_FrameError stays 0.
REQ-029 16 bits 0x4000, then CS_N high -> no write strobe, one o_FrameError pulse, and the outputs keep their previous values.
REQ-030 40 bits beginning 0xC3FF_00AA -> write strobe with Number=0xC3FF and Value=0x00AA after bit 32; one o_FrameError pulse at CS_N high.
REQ-031 Reset pulsed after 20 bits, then a full frame 0x4001_0007 -> no strobe for the first frame; a single strobe with 0x4001 / 0x0007 for the second.
REQ-032 Back-to-back frames 0xC000_0100 then 0xC001_0200, separated by the minimum CS_N high time -> two strobes carrying the respective values in order.
REQ-033 CS_N rise coincident with the 32nd SCLK edge -> no write strobe and one o_FrameError pulse (counter 31).
